// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; loads/stores an internal synchronous data memory,
// resolves branches and presents a registered write-back bundle.
// Ports: CLK/RST (sync, active-high); VALID_IN/READY_OUT accept handshake;
//   ALU_IN, STORE_DATA, OPCD_IN, ADDR_REG_IN, OPT_BIT_IN, COND execute bundle;
//   VALID_OUT, WB_DATA, WB_EN, ADDR_REG_OUT, PC_SEL, PC_TARGET, FAULT write-back bundle;
//   ESTADO current state number.
// Option: define MEM_ADDR_CHECK_EN to fault LOAD/STORE with address bits above ADDR_W-1.
module mem_stage #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID_IN,
    output logic        READY_OUT,
    input  logic [31:0] ALU_IN,
    input  logic [15:0] STORE_DATA,
    input  logic [4:0]  OPCD_IN,
    input  logic [4:0]  ADDR_REG_IN,
    input  logic        OPT_BIT_IN,
    input  logic        COND,
    output logic        VALID_OUT,
    output logic [31:0] WB_DATA,
    output logic        WB_EN,
    output logic [4:0]  ADDR_REG_OUT,
    output logic        PC_SEL,
    output logic [15:0] PC_TARGET,
    output logic        FAULT,
    output logic [2:0]  ESTADO
);

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_LOAD  = 5'd20;
    localparam logic [4:0] OP_STORE = 5'd21;
    localparam logic [4:0] OP_BRZ   = 5'd22;
    localparam logic [4:0] OP_JMP   = 5'd23;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        RDWAIT = 3'd2,
        DONE   = 3'd3
    } state_t;

    state_t state, state_n;

    logic [31:0] alu_q;
    logic [15:0] sdata_q;
    logic [4:0]  op_q;
    logic [4:0]  dst_q;
    logic        opt_q;
    logic        cond_q;
    logic [2:0]  cnt_q, cnt_n;
    logic [15:0] rdata_q;

    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_en_q, wb_en_d;
    logic        pc_sel_q, pc_sel_d;
    logic [15:0] pc_tgt_q, pc_tgt_d;
    logic        fault_q, fault_d;
    logic        load_out;
    logic        mem_we;
    logic        addr_bad;

    logic [15:0] mem [2**ADDR_W];

    wire [ADDR_W-1:0] addr = alu_q[ADDR_W-1:0];

    wire is_load  = (op_q == OP_LOAD);
    wire is_store = (op_q == OP_STORE);
    wire is_brz   = (op_q == OP_BRZ);
    wire is_jmp   = (op_q == OP_JMP);
    wire is_nop   = (op_q == OP_NOP);

    wire [31:0] ext_word = opt_q ? {{16{rdata_q[15]}}, rdata_q}
                                 : {16'h0000, rdata_q};

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = |alu_q[31:ADDR_W];
`else
    assign addr_bad = 1'b0;
`endif

    // Reset blocks a STORE whose EXEC edge coincides with RST; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST)
            mem[addr] <= sdata_q;
        rdata_q <= mem[addr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt_q     <= '0;
            alu_q     <= '0;
            sdata_q   <= '0;
            op_q      <= '0;
            dst_q     <= '0;
            opt_q     <= 1'b0;
            cond_q    <= 1'b0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            pc_sel_q  <= 1'b0;
            pc_tgt_q  <= '0;
            fault_q   <= 1'b0;
            ADDR_REG_OUT <= '0;
        end else begin
            state <= state_n;
            cnt_q <= cnt_n;
            if (state == IDLE && VALID_IN) begin
                alu_q   <= ALU_IN;
                sdata_q <= STORE_DATA;
                op_q    <= OPCD_IN;
                dst_q   <= ADDR_REG_IN;
                opt_q   <= OPT_BIT_IN;
                cond_q  <= COND;
            end
            // Bundle registers change only when DONE is entered, so they hold between results.
            if (load_out) begin
                wb_data_q    <= wb_data_d;
                wb_en_q      <= wb_en_d;
                pc_sel_q     <= pc_sel_d;
                pc_tgt_q     <= pc_tgt_d;
                fault_q      <= fault_d;
                ADDR_REG_OUT <= dst_q;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt_q;
        load_out  = 1'b0;
        mem_we    = 1'b0;
        wb_data_d = '0;
        wb_en_d   = 1'b0;
        pc_sel_d  = 1'b0;
        pc_tgt_d  = '0;
        fault_d   = 1'b0;
        case (state)
            IDLE: begin
                if (VALID_IN)
                    state_n = EXEC;
            end
            EXEC: begin
                state_n  = DONE;
                load_out = 1'b1;
                if ((is_load || is_store) && addr_bad) begin
                    fault_d = 1'b1;
                end else begin
                    unique case (1'b1)
                        is_store: mem_we = 1'b1;
                        is_load: begin
                            state_n  = RDWAIT;
                            load_out = 1'b0;
                            cnt_n    = 3'(RD_LAT);
                        end
                        is_brz: begin
                            pc_sel_d = cond_q;
                            pc_tgt_d = alu_q[15:0];
                        end
                        is_jmp: begin
                            pc_sel_d = 1'b1;
                            pc_tgt_d = alu_q[15:0];
                        end
                        is_nop: ;
                        default: begin
                            wb_data_d = alu_q;
                            wb_en_d   = 1'b1;
                        end
                    endcase
                end
            end
            RDWAIT: begin
                cnt_n = cnt_q - 3'd1;
                if (cnt_n == 3'd0) begin
                    state_n   = DONE;
                    load_out  = 1'b1;
                    wb_data_d = ext_word;
                    wb_en_d   = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // r0 is hardwired, never written back.
        if (dst_q == 5'd0)
            wb_en_d = 1'b0;
    end

    assign READY_OUT = (state == IDLE);
    assign VALID_OUT = (state == DONE);
    assign ESTADO    = state;
    assign WB_DATA   = wb_data_q;
    assign WB_EN     = wb_en_q & VALID_OUT;
    assign PC_SEL    = pc_sel_q & VALID_OUT;
    assign PC_TARGET = pc_tgt_q;
    assign FAULT     = fault_q & VALID_OUT;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Each scenario task drives a bundle and compares the write-back outputs inline.
module tb_mem_stage;

    localparam int RD_LAT = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        VALID_IN = 1'b0;
    logic        READY_OUT;
    logic [31:0] ALU_IN = '0;
    logic [15:0] STORE_DATA = '0;
    logic [4:0]  OPCD_IN = '0;
    logic [4:0]  ADDR_REG_IN = '0;
    logic        OPT_BIT_IN = 1'b0;
    logic        COND = 1'b0;
    logic        VALID_OUT;
    logic [31:0] WB_DATA;
    logic        WB_EN;
    logic [4:0]  ADDR_REG_OUT;
    logic        PC_SEL;
    logic [15:0] PC_TARGET;
    logic        FAULT;
    logic [2:0]  ESTADO;

    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(8), .RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
        .ALU_IN(ALU_IN), .STORE_DATA(STORE_DATA), .OPCD_IN(OPCD_IN),
        .ADDR_REG_IN(ADDR_REG_IN), .OPT_BIT_IN(OPT_BIT_IN), .COND(COND),
        .VALID_OUT(VALID_OUT), .WB_DATA(WB_DATA), .WB_EN(WB_EN),
        .ADDR_REG_OUT(ADDR_REG_OUT), .PC_SEL(PC_SEL), .PC_TARGET(PC_TARGET),
        .FAULT(FAULT), .ESTADO(ESTADO)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [4:0] op, input logic [31:0] alu,
                         input logic [15:0] sd, input logic [4:0] dst,
                         input logic opt, input logic cond);
        OPCD_IN = op; ALU_IN = alu; STORE_DATA = sd;
        ADDR_REG_IN = dst; OPT_BIT_IN = opt; COND = cond;
    endtask

    // Issues a bundle at the current negedge (stage idle) and waits for VALID_OUT.
    // cyc = negedges from the accepting cycle to the first one with VALID_OUT high.
    task automatic run(input logic [4:0] op, input logic [31:0] alu,
                       input logic [15:0] sd, input logic [4:0] dst,
                       input logic opt, input logic cond, output int cyc);
        drive(op, alu, sd, dst, opt, cond);
        VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        cyc = 1;
        while (!VALID_OUT && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        checks++; if (ESTADO !== 3'd0) begin errors++; $display("FAIL rst_estado got %0d want 0", ESTADO); end
        checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", VALID_OUT); end
        checks++; if (READY_OUT !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", READY_OUT); end
        checks++; if ({WB_EN, PC_SEL, FAULT} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {WB_EN, PC_SEL, FAULT}); end
        checks++; if (WB_DATA !== 32'h0) begin errors++; $display("FAIL rst_wbdata got %h want 0", WB_DATA); end
        checks++; if ({PC_TARGET, ADDR_REG_OUT} !== 21'h0) begin errors++; $display("FAIL rst_tgt_reg got %h want 0", {PC_TARGET, ADDR_REG_OUT}); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_alu;
        checks++; if (ESTADO !== 3'd0) begin errors++; $display("FAIL alu_st0 got %0d want 0", ESTADO); end
        drive(5'd5, 32'h0001_2345, 16'h0, 5'd3, 1'b0, 1'b0);
        VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        checks++; if (ESTADO !== 3'd1) begin errors++; $display("FAIL alu_st1 got %0d want 1", ESTADO); end
        checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL alu_early_valid got %b want 0", VALID_OUT); end
        @(negedge CLK);
        checks++; if (ESTADO !== 3'd3) begin errors++; $display("FAIL alu_st3 got %0d want 3", ESTADO); end
        checks++; if (VALID_OUT !== 1'b1) begin errors++; $display("FAIL alu_valid got %b want 1", VALID_OUT); end
        checks++; if (WB_DATA !== 32'h0001_2345) begin errors++; $display("FAIL alu_wbdata got %h want 00012345", WB_DATA); end
        checks++; if (WB_EN !== 1'b1) begin errors++; $display("FAIL alu_wben got %b want 1", WB_EN); end
        checks++; if (ADDR_REG_OUT !== 5'd3) begin errors++; $display("FAIL alu_reg got %0d want 3", ADDR_REG_OUT); end
        @(negedge CLK);
        checks++; if (ESTADO !== 3'd0) begin errors++; $display("FAIL alu_st_back got %0d want 0", ESTADO); end
        checks++; if ({VALID_OUT, WB_EN} !== 2'b00) begin errors++; $display("FAIL alu_pulse got %b want 00", {VALID_OUT, WB_EN}); end
        checks++; if (WB_DATA !== 32'h0001_2345) begin errors++; $display("FAIL alu_hold got %h want 00012345", WB_DATA); end
    endtask

    task automatic test_store_load;
        int cyc;
        run(5'd21, 32'h10, 16'hBEEF, 5'd0, 1'b0, 1'b0, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL st_lat got %0d want 2", cyc); end
        checks++; if ({WB_EN, WB_DATA} !== 33'h0) begin errors++; $display("FAIL st_wb got %h want 0", {WB_EN, WB_DATA}); end
        @(negedge CLK);
        run(5'd20, 32'h10, 16'h0, 5'd4, 1'b1, 1'b0, cyc);
        checks++; if (cyc !== 2 + RD_LAT) begin errors++; $display("FAIL ld_lat got %0d want %0d", cyc, 2 + RD_LAT); end
        checks++; if (WB_DATA !== 32'hFFFF_BEEF) begin errors++; $display("FAIL ld_sext got %h want ffffbeef", WB_DATA); end
        checks++; if (WB_EN !== 1'b1) begin errors++; $display("FAIL ld_wben got %b want 1", WB_EN); end
        @(negedge CLK);
        run(5'd20, 32'h10, 16'h0, 5'd4, 1'b0, 1'b0, cyc);
        checks++; if (WB_DATA !== 32'h0000_BEEF) begin errors++; $display("FAIL ld_zext got %h want 0000beef", WB_DATA); end
        @(negedge CLK);
    endtask

    task automatic test_branch;
        int cyc;
        run(5'd22, 32'h40, 16'h0, 5'd9, 1'b0, 1'b1, cyc);
        checks++; if (PC_SEL !== 1'b1) begin errors++; $display("FAIL brz_t_sel got %b want 1", PC_SEL); end
        checks++; if (PC_TARGET !== 16'h0040) begin errors++; $display("FAIL brz_t_tgt got %h want 0040", PC_TARGET); end
        checks++; if (WB_EN !== 1'b0) begin errors++; $display("FAIL brz_wben got %b want 0", WB_EN); end
        @(negedge CLK);
        checks++; if (PC_SEL !== 1'b0) begin errors++; $display("FAIL brz_qual got %b want 0", PC_SEL); end
        run(5'd22, 32'h40, 16'h0, 5'd9, 1'b0, 1'b0, cyc);
        checks++; if (PC_SEL !== 1'b0) begin errors++; $display("FAIL brz_nt_sel got %b want 0", PC_SEL); end
        @(negedge CLK);
        run(5'd23, 32'h0000_1234, 16'h0, 5'd0, 1'b0, 1'b0, cyc);
        checks++; if (PC_SEL !== 1'b1) begin errors++; $display("FAIL jmp_sel got %b want 1", PC_SEL); end
        checks++; if (PC_TARGET !== 16'h1234) begin errors++; $display("FAIL jmp_tgt got %h want 1234", PC_TARGET); end
        @(negedge CLK);
    endtask

    task automatic test_r0_and_ignore;
        int cyc;
        run(5'd20, 32'h10, 16'h0, 5'd0, 1'b1, 1'b0, cyc);
        checks++; if (VALID_OUT !== 1'b1) begin errors++; $display("FAIL r0_valid got %b want 1", VALID_OUT); end
        checks++; if (WB_EN !== 1'b0) begin errors++; $display("FAIL r0_wben got %b want 0", WB_EN); end
        @(negedge CLK);
        drive(5'd20, 32'h10, 16'h0, 5'd5, 1'b0, 1'b0);
        VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        @(negedge CLK);
        checks++; if (ESTADO !== 3'd2) begin errors++; $display("FAIL ign_st got %0d want 2", ESTADO); end
        checks++; if (READY_OUT !== 1'b0) begin errors++; $display("FAIL ign_ready got %b want 0", READY_OUT); end
        drive(5'd5, 32'h0000_DEAD, 16'h0, 5'd7, 1'b0, 1'b0);
        VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        cyc = 0;
        while (!VALID_OUT && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        checks++; if (WB_DATA !== 32'h0000_BEEF) begin errors++; $display("FAIL ign_data got %h want 0000beef", WB_DATA); end
        checks++; if (ADDR_REG_OUT !== 5'd5) begin errors++; $display("FAIL ign_reg got %0d want 5", ADDR_REG_OUT); end
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (ESTADO !== 3'd0) begin errors++; $display("FAIL ign_idle got %0d want 0", ESTADO); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        drive(5'd20, 32'h10, 16'h0, 5'd6, 1'b0, 1'b0);
        VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        @(negedge CLK);
        checks++; if (ESTADO !== 3'd2) begin errors++; $display("FAIL rmid_st got %0d want 2", ESTADO); end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++; if (ESTADO !== 3'd0) begin errors++; $display("FAIL rmid_idle got %0d want 0", ESTADO); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL rmid_valid%0d got %b want 0", i, VALID_OUT); end
            @(negedge CLK);
        end
        run(5'd21, 32'h20, 16'h1111, 5'd0, 1'b0, 1'b0, cyc);
        @(negedge CLK);
        drive(5'd21, 32'h20, 16'h2222, 5'd0, 1'b0, 1'b0);
        VALID_IN = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++; if ({ESTADO, VALID_OUT} !== 4'd0) begin errors++; $display("FAIL rst_st_idle got %h want 0", {ESTADO, VALID_OUT}); end
        run(5'd20, 32'h20, 16'h0, 5'd1, 1'b0, 1'b0, cyc);
        checks++; if (WB_DATA !== 32'h0000_1111) begin errors++; $display("FAIL rst_store got %h want 00001111", WB_DATA); end
        @(negedge CLK);
    endtask

    task automatic test_wrap;
        int cyc;
        run(5'd21, 32'h0000_0110, 16'h5A5A, 5'd0, 1'b0, 1'b0, cyc);
`ifdef MEM_ADDR_CHECK_EN
        checks++; if (FAULT !== 1'b1) begin errors++; $display("FAIL chk_st_fault got %b want 1", FAULT); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL chk_st_lat got %0d want 2", cyc); end
        @(negedge CLK);
        checks++; if (FAULT !== 1'b0) begin errors++; $display("FAIL chk_qual got %b want 0", FAULT); end
        run(5'd20, 32'h10, 16'h0, 5'd2, 1'b0, 1'b0, cyc);
        checks++; if (WB_DATA !== 32'h0000_BEEF) begin errors++; $display("FAIL chk_nowrite got %h want 0000beef", WB_DATA); end
        @(negedge CLK);
        run(5'd20, 32'h0000_0110, 16'h0, 5'd2, 1'b1, 1'b0, cyc);
        checks++; if ({FAULT, WB_EN} !== 2'b10) begin errors++; $display("FAIL chk_ld_flags got %b want 10", {FAULT, WB_EN}); end
        checks++; if (WB_DATA !== 32'h0) begin errors++; $display("FAIL chk_ld_data got %h want 0", WB_DATA); end
`else
        checks++; if (FAULT !== 1'b0) begin errors++; $display("FAIL wrap_fault got %b want 0", FAULT); end
        @(negedge CLK);
        run(5'd20, 32'h10, 16'h0, 5'd2, 1'b0, 1'b0, cyc);
        checks++; if (WB_DATA !== 32'h0000_5A5A) begin errors++; $display("FAIL wrap_data got %h want 00005a5a", WB_DATA); end
`endif
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_store_load();
        test_branch();
        test_r0_and_ignore();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
